// File: rtl/sha1_pkg.sv
// sha1_pkg
//   Shared definitions for the multi-block SHA-1 core:
//   - SHA-1 initial chaining value H0..H4 and the four round constants
//   - number of rounds per block
//   - FSM state encoding
//   - round helpers: f() selection, K selection and 32-bit rotate-left
package sha1_pkg;

    localparam int ROUNDS = 80;

    localparam logic [31:0] IV_H0 = 32'h67452301;
    localparam logic [31:0] IV_H1 = 32'hEFCDAB89;
    localparam logic [31:0] IV_H2 = 32'h98BADCFE;
    localparam logic [31:0] IV_H3 = 32'h10325476;
    localparam logic [31:0] IV_H4 = 32'hC3D2E1F0;
    localparam logic [159:0] SHA1_IV = {IV_H0, IV_H1, IV_H2, IV_H3, IV_H4};

    localparam logic [31:0] K_00_19 = 32'h5A827999;
    localparam logic [31:0] K_20_39 = 32'h6ED9EBA1;
    localparam logic [31:0] K_40_59 = 32'h8F1BBCDC;
    localparam logic [31:0] K_60_79 = 32'hCA62C1D6;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ROUND = 2'd1,
        ST_FINAL = 2'd2
    } state_t;

    function automatic logic [31:0] rotl(input logic [31:0] x, input int unsigned n);
        logic [31:0] r;
        r = (x << n) | (x >> (32 - n));
        return r;
    endfunction

    // Round function: Ch for 0-19, Parity for 20-39 and 60-79, Maj for 40-59.
    function automatic logic [31:0] sha1_f(input logic [6:0] t, input logic [31:0] b,
                                           input logic [31:0] c, input logic [31:0] d);
        logic [31:0] r;
        if (t < 7'd20) begin
            r = (b & c) | (~b & d);
        end else if (t < 7'd40) begin
            r = b ^ c ^ d;
        end else if (t < 7'd60) begin
            r = (b & c) | (b & d) | (c & d);
        end else begin
            r = b ^ c ^ d;
        end
        return r;
    endfunction

    function automatic logic [31:0] sha1_k(input logic [6:0] t);
        logic [31:0] r;
        if (t < 7'd20) begin
            r = K_00_19;
        end else if (t < 7'd40) begin
            r = K_20_39;
        end else if (t < 7'd60) begin
            r = K_40_59;
        end else begin
            r = K_60_79;
        end
        return r;
    endfunction

endpackage

// File: rtl/sha1_round.sv
// sha1_round
//   One combinational SHA-1 round. Chained UNROLL times inside sha1_core_mb.
//   Ports:
//     a_in..e_in  working variables before the round
//     w_in        message schedule word W[t]
//     t_in        round index 0..79 (selects f() and K)
//     a_out..e_out working variables after the round
module sha1_round
    import sha1_pkg::*;
(
    input  logic [31:0] a_in,
    input  logic [31:0] b_in,
    input  logic [31:0] c_in,
    input  logic [31:0] d_in,
    input  logic [31:0] e_in,
    input  logic [31:0] w_in,
    input  logic [6:0]  t_in,
    output logic [31:0] a_out,
    output logic [31:0] b_out,
    output logic [31:0] c_out,
    output logic [31:0] d_out,
    output logic [31:0] e_out
);

    logic [31:0] temp;

    // All sums wrap modulo 2^32 by virtue of the 32-bit result.
    always_comb begin
        temp = rotl(a_in, 5) + sha1_f(t_in, b_in, c_in, d_in) + e_in + sha1_k(t_in) + w_in;
    end

    assign a_out = temp;
    assign b_out = a_in;
    assign c_out = rotl(b_in, 30);
    assign d_out = c_in;
    assign e_out = d_in;

endmodule

// File: rtl/sha1_core_mb.sv
// sha1_core_mb
//   Iterative SHA-1 compression core with multi-block chaining, UNROLL rounds
//   per clock (1, 2, 4 or 5).
//   Ports:
//     CLK      clock, rising edge
//     nRST     asynchronous active-low reset
//     START    hash one block (sampled only in IDLE)
//     FIRST    with START: 1 = chain from IV, 0 = chain from current SHA1OUT
//     SHA1IN   padded 512-bit block, word 0 in [511:480]
//     BUSY     block in progress (ROUND or FINAL)
//     DONE     one-cycle pulse after SHA1OUT has been updated
//     SHA1OUT  chaining digest H0..H4, H0 in [159:128]
module sha1_core_mb
    import sha1_pkg::*;
#(
    parameter int UNROLL = 1
)
(
    input  logic         CLK,
    input  logic         nRST,
    input  logic         START,
    input  logic         FIRST,
    input  logic [511:0] SHA1IN,
    output logic         BUSY,
    output logic         DONE,
    output logic [159:0] SHA1OUT
);

    generate
        if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 4 || UNROLL == 5)) begin : g_bad_unroll
            $error("sha1_core_mb: UNROLL must be 1, 2, 4 or 5");
        end
    endgenerate

    state_t        state_q, state_d;
    logic [6:0]    cnt_q, cnt_d;
    logic [31:0]   a_q, a_d, b_q, b_d, c_q, c_d, d_q, d_d, e_q, e_d;
    logic [31:0]   w_q [0:15];
    logic [31:0]   w_d [0:15];
    logic [31:0]   shift_w [0:15];
    logic          first_q, first_d;
    logic [159:0]  out_q, out_d;
    logic          done_q, done_d;

    logic [31:0]   last_a, last_b, last_c, last_d, last_e;
    logic [159:0]  chain;

    genvar gi;

    // Extended schedule view: entry k holds W[cnt+k]. Entries 0..15 are the
    // stored window; entries 16.. are expanded on the fly so the window can
    // slide UNROLL words per edge.
    for (gi = 0; gi < 16 + UNROLL; gi++) begin : g_ext
        logic [31:0] w;
        if (gi < 16) begin : g_stored
            assign w = w_q[gi];
        end else begin : g_expand
            assign w = rotl(g_ext[gi-3].w ^ g_ext[gi-8].w ^ g_ext[gi-14].w ^ g_ext[gi-16].w, 1);
        end
    end

    for (gi = 0; gi < 16; gi++) begin : g_shift
        assign shift_w[gi] = g_ext[gi+UNROLL].w;
    end

    // Round chain; each stage evaluates its own round index so the f()/K
    // selection switches correctly inside an unrolled group.
    for (gi = 0; gi < UNROLL; gi++) begin : g_rnd
        logic [31:0] a_i, b_i, c_i, d_i, e_i;
        logic [31:0] a_o, b_o, c_o, d_o, e_o;
        logic [6:0]  t_i;

        if (gi == 0) begin : g_head
            assign a_i = a_q;
            assign b_i = b_q;
            assign c_i = c_q;
            assign d_i = d_q;
            assign e_i = e_q;
        end else begin : g_link
            assign a_i = g_rnd[gi-1].a_o;
            assign b_i = g_rnd[gi-1].b_o;
            assign c_i = g_rnd[gi-1].c_o;
            assign d_i = g_rnd[gi-1].d_o;
            assign e_i = g_rnd[gi-1].e_o;
        end

        assign t_i = cnt_q + 7'(gi);

        sha1_round u_round (
            .a_in  (a_i),
            .b_in  (b_i),
            .c_in  (c_i),
            .d_in  (d_i),
            .e_in  (e_i),
            .w_in  (g_ext[gi].w),
            .t_in  (t_i),
            .a_out (a_o),
            .b_out (b_o),
            .c_out (c_o),
            .d_out (d_o),
            .e_out (e_o)
        );
    end

    assign last_a = g_rnd[UNROLL-1].a_o;
    assign last_b = g_rnd[UNROLL-1].b_o;
    assign last_c = g_rnd[UNROLL-1].c_o;
    assign last_d = g_rnd[UNROLL-1].d_o;
    assign last_e = g_rnd[UNROLL-1].e_o;

    // SHA1OUT cannot change while a block is in flight, so the chaining value
    // is recovered from the FIRST flag instead of being stored separately.
    assign chain = first_q ? SHA1_IV : out_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        c_d     = c_q;
        d_d     = d_q;
        e_d     = e_q;
        w_d     = w_q;
        first_d = first_q;
        out_d   = out_q;
        done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (START) begin
                    for (int j = 0; j < 16; j++) begin
                        w_d[j] = SHA1IN[511 - 32*j -: 32];
                    end
                    if (FIRST) begin
                        a_d = IV_H0;
                        b_d = IV_H1;
                        c_d = IV_H2;
                        d_d = IV_H3;
                        e_d = IV_H4;
                    end else begin
                        a_d = out_q[159:128];
                        b_d = out_q[127:96];
                        c_d = out_q[95:64];
                        d_d = out_q[63:32];
                        e_d = out_q[31:0];
                    end
                    first_d = FIRST;
                    cnt_d   = '0;
                    state_d = ST_ROUND;
                end
            end

            ST_ROUND: begin
                a_d   = last_a;
                b_d   = last_b;
                c_d   = last_c;
                d_d   = last_d;
                e_d   = last_e;
                w_d   = shift_w;
                cnt_d = cnt_q + 7'(UNROLL);
                if (cnt_d == 7'(ROUNDS)) begin
                    state_d = ST_FINAL;
                end
            end

            ST_FINAL: begin
                out_d   = {chain[159:128] + a_q,
                           chain[127:96]  + b_q,
                           chain[95:64]   + c_q,
                           chain[63:32]   + d_q,
                           chain[31:0]    + e_q};
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
            d_q     <= '0;
            e_q     <= '0;
            for (int j = 0; j < 16; j++) begin
                w_q[j] <= '0;
            end
            first_q <= 1'b0;
            out_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            d_q     <= d_d;
            e_q     <= e_d;
            w_q     <= w_d;
            first_q <= first_d;
            out_q   <= out_d;
            done_q  <= done_d;
        end
    end

    assign BUSY    = (state_q != ST_IDLE);
    assign DONE    = done_q;
    assign SHA1OUT = out_q;

endmodule

// File: tb/tb_sha1_core_mb.sv
// tb_sha1_core_mb
//   Directed vectors for sha1_core_mb: a table of single blocks on the
//   UNROLL=1 instance, plus hand-written sequences for back-to-back chaining,
//   ignored START, mid-hash reset and UNROLL 2/4/5 latency.
module tb_sha1_core_mb;

    localparam logic [511:0] BLK_EMPTY = {32'h80000000, 480'h0};
    localparam logic [511:0] BLK_ABC   = {32'h61626380, 448'h0, 32'h00000018};
    localparam logic [511:0] BLK_TEST  = {32'h74657374, 32'h80000000, 416'h0, 32'h00000020};
    localparam logic [511:0] BLK_2A    = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                          32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                          32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                          32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
    localparam logic [511:0] BLK_2B    = {480'h0, 32'h000001c0};

    localparam logic [159:0] DIG_EMPTY = 160'hda39a3ee5e6b4b0d3255bfef95601890afd80709;
    localparam logic [159:0] DIG_ABC   = 160'ha9993e364706816aba3e25717850c26c9cd0d89d;
    localparam logic [159:0] DIG_TEST  = 160'ha94a8fe5ccb19ba61c4c0873d391e987982fbbd3;
    localparam logic [159:0] DIG_2BLK  = 160'h84983e441c3bd26ebaae4aa1f95129e5e54670f1;

    typedef struct packed {
        logic [511:0] blk;
        logic         first;
        logic [159:0] dig;
    } vec_t;

    logic         clk = 1'b0;
    logic         nrst;
    logic         start;
    logic         first;
    logic [511:0] sha1in;
    logic         busy;
    logic         done;
    logic [159:0] out;

    logic         start_m;
    logic         first_m;
    logic [511:0] sha1in_m;
    logic         busy2, done2, busy4, done4, busy5, done5;
    logic [159:0] out2, out4, out5;

    int total = 0;
    int bad   = 0;

    logic         done_prev;
    logic [159:0] out_prev;
    logic         rst_flag;

    always #5 clk = ~clk;

    sha1_core_mb #(.UNROLL(1)) dut (
        .CLK(clk), .nRST(nrst), .START(start), .FIRST(first), .SHA1IN(sha1in),
        .BUSY(busy), .DONE(done), .SHA1OUT(out)
    );

    sha1_core_mb #(.UNROLL(2)) dut2 (
        .CLK(clk), .nRST(nrst), .START(start_m), .FIRST(first_m), .SHA1IN(sha1in_m),
        .BUSY(busy2), .DONE(done2), .SHA1OUT(out2)
    );

    sha1_core_mb #(.UNROLL(4)) dut4 (
        .CLK(clk), .nRST(nrst), .START(start_m), .FIRST(first_m), .SHA1IN(sha1in_m),
        .BUSY(busy4), .DONE(done4), .SHA1OUT(out4)
    );

    sha1_core_mb #(.UNROLL(5)) dut5 (
        .CLK(clk), .nRST(nrst), .START(start_m), .FIRST(first_m), .SHA1IN(sha1in_m),
        .BUSY(busy5), .DONE(done5), .SHA1OUT(out5)
    );

    // Advance one edge, sample 1 time unit later and check the per-cycle
    // invariants of the UNROLL=1 instance.
    task automatic tick();
        @(posedge clk);
        #1;
        total++;
        if ((done && done_prev) || (busy && done) || ((out != out_prev) && !done && !rst_flag)) begin
            bad++;
            $display("FAIL invariant: done=%0b prev_done=%0b busy=%0b out=%h prev_out=%h",
                     done, done_prev, busy, out, out_prev);
        end
        done_prev = done;
        out_prev  = out;
        rst_flag  = 1'b0;
    endtask

    task automatic check_vec(input string nm, input logic [159:0] act, input logic [159:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end else begin
            $display("ok   %s: %h", nm, act);
        end
    endtask

    task automatic check_int(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end else begin
            $display("ok   %s: %0d", nm, act);
        end
    endtask

    // Issue one block on the UNROLL=1 instance and wait for DONE. Returns in
    // the DONE cycle so a following call exercises back-to-back issue.
    task automatic run_block(input string nm, input logic [511:0] blk, input logic fst,
                             input logic [159:0] exp, input bit chk_dig);
        int lat;
        start  = 1'b1;
        first  = fst;
        sha1in = blk;
        tick();
        start = 1'b0;
        first = ~fst;
        for (int j = 0; j < 16; j++) begin
            sha1in[32*j +: 32] = $urandom();
        end
        check_int({nm, " busy_after_accept"}, int'(busy), 1);
        lat = 0;
        for (int n = 1; n <= 200; n++) begin
            tick();
            if (done) begin
                lat = n;
                break;
            end
        end
        check_int({nm, " latency"}, lat, 81);
        if (chk_dig) begin
            check_vec({nm, " digest"}, out, exp);
        end
    endtask

    vec_t  vecs  [0:3];
    string names [0:3];

    initial begin
        int lat2, lat4, lat5;
        int ndone, first_done;

        vecs[0] = '{blk: BLK_EMPTY, first: 1'b1, dig: DIG_EMPTY}; names[0] = "empty";
        vecs[1] = '{blk: BLK_ABC,   first: 1'b1, dig: DIG_ABC};   names[1] = "abc";
        vecs[2] = '{blk: BLK_TEST,  first: 1'b1, dig: DIG_TEST};  names[2] = "test";
        vecs[3] = '{blk: BLK_ABC,   first: 1'b1, dig: DIG_ABC};   names[3] = "abc_again";

        nrst     = 1'b0;
        start    = 1'b0;
        first    = 1'b0;
        sha1in   = '0;
        start_m  = 1'b0;
        first_m  = 1'b1;
        sha1in_m = BLK_ABC;
        rst_flag = 1'b1;
        done_prev = 1'b0;
        out_prev  = '0;

        tick();
        rst_flag = 1'b1;
        tick();
        check_int("reset busy", int'(busy), 0);
        check_int("reset done", int'(done), 0);
        check_vec("reset sha1out", out, 160'h0);
        nrst = 1'b1;
        tick();

        // Table: single blocks, each issued in the previous DONE cycle.
        for (int i = 0; i < 4; i++) begin
            run_block(names[i], vecs[i].blk, vecs[i].first, vecs[i].dig, 1'b1);
        end

        // Two-block message, block 2 issued in block 1's DONE cycle.
        run_block("2blk_b1", BLK_2A, 1'b1, '0, 1'b0);
        run_block("2blk_b2", BLK_2B, 1'b0, DIG_2BLK, 1'b1);
        tick();

        // START during ROUND (with new data) and during FINAL is ignored.
        start  = 1'b1;
        first  = 1'b1;
        sha1in = BLK_ABC;
        tick();
        start = 1'b0;
        ndone = 0;
        first_done = 0;
        for (int n = 1; n <= 100; n++) begin
            if (n == 40) begin
                start = 1'b1;
                first = 1'b0;
                for (int j = 0; j < 16; j++) begin
                    sha1in[32*j +: 32] = $urandom();
                end
            end
            if (n == 45) start = 1'b0;
            if (n == 81) start = 1'b1;
            if (n == 82) start = 1'b0;
            tick();
            if (done) begin
                ndone++;
                if (first_done == 0) first_done = n;
            end
            if (n == 82) check_int("final_start busy", int'(busy), 0);
        end
        check_int("ignored_start done_count", ndone, 1);
        check_int("ignored_start latency", first_done, 81);
        check_vec("ignored_start digest", out, DIG_ABC);

        // Asynchronous reset in the middle of a hash.
        start  = 1'b1;
        first  = 1'b1;
        sha1in = BLK_ABC;
        tick();
        start = 1'b0;
        repeat (30) tick();
        #2;
        rst_flag = 1'b1;
        nrst = 1'b0;
        #1;
        check_vec("async_rst sha1out", out, 160'h0);
        check_int("async_rst busy", int'(busy), 0);
        check_int("async_rst done", int'(done), 0);
        tick();
        rst_flag = 1'b1;
        tick();
        nrst = 1'b1;
        tick();
        run_block("after_rst abc", BLK_ABC, 1'b1, DIG_ABC, 1'b1);
        tick();

        // UNROLL 2/4/5 instances run "abc" together.
        start_m = 1'b1;
        tick();
        start_m = 1'b0;
        lat2 = 0;
        lat4 = 0;
        lat5 = 0;
        for (int n = 1; n <= 100; n++) begin
            tick();
            if (done2 && lat2 == 0) lat2 = n;
            if (done4 && lat4 == 0) lat4 = n;
            if (done5 && lat5 == 0) lat5 = n;
        end
        check_int("u2 latency", lat2, 41);
        check_int("u4 latency", lat4, 21);
        check_int("u5 latency", lat5, 17);
        check_vec("u2 digest", out2, DIG_ABC);
        check_vec("u4 digest", out4, DIG_ABC);
        check_vec("u5 digest", out5, DIG_ABC);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
